// File: rtl/bus_target_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_target_if
// Description : Grouping of the 8-bit req/ack handshake bus between the CPU
//               bus master and the bus_target endpoint.
//               Signals:
//                 bus_handshake_req  master -> target  phase request
//                 bus_state[1:0]     master -> target  phase code
//                 bus_data_in[7:0]   master -> target  address / write byte
//                 bus_handshake_ack  target -> master  phase acknowledge
//                 bus_data_out[7:0]  target -> master  read byte
//                 bus_output_enable  target -> master  target drives the bus
//               Modports: master (bus master side), slave (bus_target side).
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_target_if;
   logic       bus_handshake_req;
   logic [1:0] bus_state;
   logic [7:0] bus_data_in;
   logic       bus_handshake_ack;
   logic [7:0] bus_data_out;
   logic       bus_output_enable;

   modport master (
      output bus_handshake_req,
      output bus_state,
      output bus_data_in,
      input  bus_handshake_ack,
      input  bus_data_out,
      input  bus_output_enable
   );

   modport slave (
      input  bus_handshake_req,
      input  bus_state,
      input  bus_data_in,
      output bus_handshake_ack,
      output bus_data_out,
      output bus_output_enable
   );
endinterface
`default_nettype wire

// File: rtl/bus_target.sv
`default_nettype none
// ============================================================================
// Module      : bus_target
// Description : Far-side endpoint of the 8-bit three-phase handshake bus.
//               Collects address low / address high bytes, then performs a
//               read or write on a variable-latency backing-memory port and
//               completes every phase with req/ack.
// Ports       :
//   clk               in   clock, rising edge
//   rst_n             in   asynchronous active-low reset
//   bus               slave modport of bus_target_if (req/state/data/ack/oe)
//   mem_req           out  memory access request, held until mem_ready
//   mem_we            out  1 = write, 0 = read
//   mem_addr[15:0]    out  {addr_hi, addr_lo}
//   mem_wdata[7:0]    out  write byte
//   mem_rdata[7:0]    in   read byte, valid with mem_ready
//   mem_ready         in   access completion
//   seq_err           out  sticky phase-order violation flag
// Config      : define BUS_TARGET_SYNC_EN to pass bus_handshake_req through a
//               2-flop synchronizer (all handshake latencies +2 cycles).
// Revision    : 1.0 - initial release
// ============================================================================
module bus_target (
   input  wire             clk,
   input  wire             rst_n,
   bus_target_if.slave     bus,
   output logic            mem_req,
   output logic            mem_we,
   output logic [15:0]     mem_addr,
   output logic [7:0]      mem_wdata,
   input  wire  [7:0]      mem_rdata,
   input  wire             mem_ready,
   output logic            seq_err
);

   localparam logic [1:0] c_PH_ADDR_LO = 2'b00;
   localparam logic [1:0] c_PH_ADDR_HI = 2'b01;
   localparam logic [1:0] c_PH_READ    = 2'b10;
   localparam logic [1:0] c_PH_WRITE   = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_MEM   = 2'd1,
      ST_SETUP = 2'd2,
      ST_ACK   = 2'd3
   } state_t;

   // Phase-order tracker: which phase the master should issue next.
   typedef enum logic [1:0] {
      EXP_LO   = 2'd0,
      EXP_HI   = 2'd1,
      EXP_DATA = 2'd2
   } expect_t;

   state_t      r_state,     w_state_nxt;
   expect_t     r_expect,    w_expect_nxt;
   logic        r_ack,       w_ack_nxt;
   logic        r_oe,        w_oe_nxt;
   logic [7:0]  r_dout,      w_dout_nxt;
   logic        r_mem_req,   w_mem_req_nxt;
   logic        r_mem_we,    w_mem_we_nxt;
   logic [7:0]  r_addr_lo,   w_addr_lo_nxt;
   logic [7:0]  r_addr_hi,   w_addr_hi_nxt;
   logic [7:0]  r_wdata,     w_wdata_nxt;
   logic        r_seq_err,   w_seq_err_nxt;
   logic        w_req;

`ifdef BUS_TARGET_SYNC_EN
   // Two-flop synchronizer on the request; bus_state/bus_data_in are stable
   // by protocol while req is high, so they are sampled unsynchronized.
   logic [1:0] r_req_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_sync <= 2'b00;
      end else begin
         r_req_sync <= {r_req_sync[0], bus.bus_handshake_req};
      end
   end

   assign w_req = r_req_sync[1];
`else
   assign w_req = bus.bus_handshake_req;
`endif

   // ------------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_expect  <= EXP_LO;
         r_ack     <= 1'b0;
         r_oe      <= 1'b0;
         r_dout    <= 8'h00;
         r_mem_req <= 1'b0;
         r_mem_we  <= 1'b0;
         r_addr_lo <= 8'h00;
         r_addr_hi <= 8'h00;
         r_wdata   <= 8'h00;
         r_seq_err <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_expect  <= w_expect_nxt;
         r_ack     <= w_ack_nxt;
         r_oe      <= w_oe_nxt;
         r_dout    <= w_dout_nxt;
         r_mem_req <= w_mem_req_nxt;
         r_mem_we  <= w_mem_we_nxt;
         r_addr_lo <= w_addr_lo_nxt;
         r_addr_hi <= w_addr_hi_nxt;
         r_wdata   <= w_wdata_nxt;
         r_seq_err <= w_seq_err_nxt;
      end
   end

   // ------------------------------------------------------------------------
   // Next-state and next-output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_state_nxt   = r_state;
      w_expect_nxt  = r_expect;
      w_ack_nxt     = r_ack;
      w_oe_nxt      = r_oe;
      w_dout_nxt    = r_dout;
      w_mem_req_nxt = r_mem_req;
      w_mem_we_nxt  = r_mem_we;
      w_addr_lo_nxt = r_addr_lo;
      w_addr_hi_nxt = r_addr_hi;
      w_wdata_nxt   = r_wdata;
      w_seq_err_nxt = r_seq_err;

      case (r_state)
         ST_IDLE: begin
            // ack is always low in IDLE, so a req left over from the previous
            // phase cannot restart a phase before ack has been low a cycle.
            if (w_req && !r_ack) begin
               case (bus.bus_state)
                  c_PH_ADDR_LO: begin
                     w_addr_lo_nxt = bus.bus_data_in;
                     w_ack_nxt     = 1'b1;
                     w_state_nxt   = ST_ACK;
                     if (r_expect != EXP_LO) begin
                        w_seq_err_nxt = 1'b1;
                     end
                     w_expect_nxt = EXP_HI;
                  end
                  c_PH_ADDR_HI: begin
                     w_addr_hi_nxt = bus.bus_data_in;
                     w_ack_nxt     = 1'b1;
                     w_state_nxt   = ST_ACK;
                     if (r_expect != EXP_HI) begin
                        w_seq_err_nxt = 1'b1;
                     end
                     w_expect_nxt = EXP_DATA;
                  end
                  c_PH_READ: begin
                     w_mem_req_nxt = 1'b1;
                     w_mem_we_nxt  = 1'b0;
                     w_state_nxt   = ST_MEM;
                     if (r_expect != EXP_DATA) begin
                        w_seq_err_nxt = 1'b1;
                     end
                     w_expect_nxt = EXP_LO;
                  end
                  c_PH_WRITE: begin
                     w_wdata_nxt   = bus.bus_data_in;
                     w_mem_req_nxt = 1'b1;
                     w_mem_we_nxt  = 1'b1;
                     w_state_nxt   = ST_MEM;
                     if (r_expect != EXP_DATA) begin
                        w_seq_err_nxt = 1'b1;
                     end
                     w_expect_nxt = EXP_LO;
                  end
                  default: begin
                     w_state_nxt = ST_IDLE;
                  end
               endcase
            end
         end

         ST_MEM: begin
            if (r_mem_req && mem_ready) begin
               w_mem_req_nxt = 1'b0;
               if (r_mem_we) begin
                  w_ack_nxt   = 1'b1;
                  w_state_nxt = ST_ACK;
               end else begin
                  // Read data goes on the bus a full cycle before ack.
                  w_dout_nxt  = mem_rdata;
                  w_oe_nxt    = 1'b1;
                  w_state_nxt = ST_SETUP;
               end
            end
         end

         ST_SETUP: begin
            w_ack_nxt   = 1'b1;
            w_state_nxt = ST_ACK;
         end

         ST_ACK: begin
            if (!w_req) begin
               w_ack_nxt   = 1'b0;
               w_oe_nxt    = 1'b0;
               w_state_nxt = ST_IDLE;
            end
         end

         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   assign bus.bus_handshake_ack = r_ack;
   assign bus.bus_data_out      = r_dout;
   assign bus.bus_output_enable = r_oe;
   assign mem_req               = r_mem_req;
   assign mem_we                = r_mem_we;
   assign mem_addr              = {r_addr_hi, r_addr_lo};
   assign mem_wdata             = r_wdata;
   assign seq_err               = r_seq_err;

endmodule
`default_nettype wire

// File: tb/tb_bus_target.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_target
// Description : Self-checking bench for bus_target. Drives master phases on
//               bus_target_if, models a variable-latency memory, and checks
//               handshake latencies, memory accesses (scoreboard queue),
//               read data, phase-order flag and asynchronous reset.
//               Latencies shift by 2 cycles when BUS_TARGET_SYNC_EN is set.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_target;

`ifdef BUS_TARGET_SYNC_EN
   localparam int c_SYNC_LAT = 2;
`else
   localparam int c_SYNC_LAT = 0;
`endif

   typedef struct packed {
      logic        we;
      logic [15:0] addr;
      logic [7:0]  wdata;
   } acc_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic [7:0]  mem_rdata = 8'h00;
   logic        mem_ready = 1'b0;
   logic        seq_err;

   int          checks = 0;
   int          errors = 0;

   int          mem_wait = 0;
   logic [7:0]  rd_val = 8'h00;
   int          mem_cnt = 0;

   acc_t        exp_q[$];
   acc_t        obs_q[$];
   logic [7:0]  exp_rd_q[$];
   int          req_cycles = 0;
   int          hs_viol = 0;
   logic        ack_prev = 1'b0;

   bus_target_if bus ();

   bus_target dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .bus       (bus.slave),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready),
      .seq_err   (seq_err)
   );

   always #5 clk = ~clk;

   // Backing memory: one-cycle mem_ready pulse after mem_wait request cycles.
   initial begin
      forever begin
         @(negedge clk);
         if (mem_ready) begin
            mem_ready = 1'b0;
         end else if (mem_req && mem_cnt >= mem_wait) begin
            mem_ready = 1'b1;
            mem_rdata = rd_val;
            mem_cnt   = 0;
         end else if (mem_req) begin
            mem_cnt = mem_cnt + 1;
         end else begin
            mem_cnt = 0;
         end
      end
   end

   // Monitor: observed accesses, request cycles, handshake-rule violations.
   always @(posedge clk) begin
      if (mem_req) req_cycles <= req_cycles + 1;
      if (mem_req && mem_ready) obs_q.push_back({mem_we, mem_addr, mem_wdata});
      if (bus.bus_handshake_ack && !ack_prev && !bus.bus_handshake_req) hs_viol <= hs_viol + 1;
      if (!bus.bus_handshake_ack && ack_prev && bus.bus_handshake_req) hs_viol <= hs_viol + 1;
      ack_prev <= bus.bus_handshake_ack;
   end

   // One master phase; returns measured latencies (-1 on timeout).
   task automatic bus_phase(input logic [1:0] code, input logic [7:0] d, input int hold,
                            output int ack_lat, output int drop_lat, output int oe_lead,
                            output logic [7:0] rd_at_ack, output int held,
                            output logic oe_after, output logic [7:0] dout_after);
      int n;
      int oe_first;
      @(negedge clk);
      bus.bus_handshake_req = 1'b1;
      bus.bus_state         = code;
      bus.bus_data_in       = d;
      ack_lat  = -1;
      oe_first = -1;
      n        = 0;
      while (n < 60) begin
         @(posedge clk); #1; n++;
         if (bus.bus_handshake_ack) begin
            ack_lat = n;
            break;
         end
         if (bus.bus_output_enable && oe_first < 0) oe_first = n;
      end
      oe_lead   = (oe_first >= 0 && ack_lat >= 0) ? (ack_lat - oe_first) : 0;
      rd_at_ack = bus.bus_data_out;
      held      = 0;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (bus.bus_handshake_ack) held++;
      end
      @(negedge clk);
      bus.bus_handshake_req = 1'b0;
      drop_lat = -1;
      n        = 0;
      while (n < 60) begin
         @(posedge clk); #1; n++;
         if (!bus.bus_handshake_ack) begin
            drop_lat = n;
            break;
         end
      end
      oe_after   = bus.bus_output_enable;
      dout_after = bus.bus_data_out;
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      bus.bus_handshake_req = 1'b0;
      bus.bus_state         = 2'b00;
      bus.bus_data_in       = 8'h00;
      repeat (3) @(negedge clk);
      checks++; if (bus.bus_handshake_ack !== 1'b0) begin errors++; $display("FAIL reset_ack: got %b want 0", bus.bus_handshake_ack); end
      checks++; if (bus.bus_output_enable !== 1'b0) begin errors++; $display("FAIL reset_oe: got %b want 0", bus.bus_output_enable); end
      checks++; if (bus.bus_data_out !== 8'h00) begin errors++; $display("FAIL reset_dout: got %h want 00", bus.bus_data_out); end
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      checks++; if (mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
      checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL reset_mem_addr: got %h want 0000", mem_addr); end
      checks++; if (mem_wdata !== 8'h00) begin errors++; $display("FAIL reset_mem_wdata: got %h want 00", mem_wdata); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL reset_seq_err: got %b want 0", seq_err); end
      rst_n = 1'b1;
   endtask

   task automatic test_write();
      int al, dl, ol, hc, rc0;
      logic [7:0] rd, da;
      logic oa;
      acc_t e, o;
      mem_wait = 0;
      bus_phase(2'b00, 8'h34, 0, al, dl, ol, rd, hc, oa, da);
      checks++; if (al !== 1 + c_SYNC_LAT) begin errors++; $display("FAIL wr_lo_ack_lat: got %0d want %0d", al, 1 + c_SYNC_LAT); end
      checks++; if (dl !== 1 + c_SYNC_LAT) begin errors++; $display("FAIL wr_lo_drop_lat: got %0d want %0d", dl, 1 + c_SYNC_LAT); end
      bus_phase(2'b01, 8'h12, 0, al, dl, ol, rd, hc, oa, da);
      checks++; if (al !== 1 + c_SYNC_LAT) begin errors++; $display("FAIL wr_hi_ack_lat: got %0d want %0d", al, 1 + c_SYNC_LAT); end
      checks++; if (mem_addr !== 16'h1234) begin errors++; $display("FAIL wr_mem_addr: got %h want 1234", mem_addr); end
      exp_q.push_back('{1'b1, 16'h1234, 8'hA5});
      rc0 = req_cycles;
      bus_phase(2'b11, 8'hA5, 0, al, dl, ol, rd, hc, oa, da);
      checks++; if (al !== 2 + c_SYNC_LAT) begin errors++; $display("FAIL wr_data_ack_lat: got %0d want %0d", al, 2 + c_SYNC_LAT); end
      checks++; if (dl !== 1 + c_SYNC_LAT) begin errors++; $display("FAIL wr_data_drop_lat: got %0d want %0d", dl, 1 + c_SYNC_LAT); end
      checks++; if (req_cycles - rc0 !== 1) begin errors++; $display("FAIL wr_req_cycles: got %0d want 1", req_cycles - rc0); end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL wr_access: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL wr_access: got %h want %h", o, e); end end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL wr_seq_err: got %b want 0", seq_err); end
   endtask

   task automatic test_read();
      int al, dl, ol, hc, rc0;
      logic [7:0] rd, da, er;
      logic oa;
      acc_t e, o;
      mem_wait = 3;
      rd_val   = 8'h5A;
      bus_phase(2'b00, 8'hCD, 0, al, dl, ol, rd, hc, oa, da);
      bus_phase(2'b01, 8'hAB, 0, al, dl, ol, rd, hc, oa, da);
      exp_q.push_back('{1'b0, 16'hABCD, 8'hA5});
      exp_rd_q.push_back(8'h5A);
      rc0 = req_cycles;
      bus_phase(2'b10, 8'h00, 0, al, dl, ol, rd, hc, oa, da);
      checks++; if (al !== 3 + mem_wait + c_SYNC_LAT) begin errors++; $display("FAIL rd_ack_lat: got %0d want %0d", al, 3 + mem_wait + c_SYNC_LAT); end
      checks++; if (ol !== 1) begin errors++; $display("FAIL rd_oe_lead: got %0d want 1", ol); end
      er = exp_rd_q.pop_front();
      checks++; if (rd !== er) begin errors++; $display("FAIL rd_data: got %h want %h", rd, er); end
      checks++; if (oa !== 1'b0) begin errors++; $display("FAIL rd_oe_drop: got %b want 0", oa); end
      checks++; if (da !== er) begin errors++; $display("FAIL rd_data_hold: got %h want %h", da, er); end
      checks++; if (req_cycles - rc0 !== mem_wait + 1) begin errors++; $display("FAIL rd_req_cycles: got %0d want %0d", req_cycles - rc0, mem_wait + 1); end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL rd_access: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL rd_access: got %h want %h", o, e); end end
   endtask

   task automatic test_handshake();
      int al, dl, ol, hc, v0;
      logic [7:0] rd, da;
      logic oa;
      v0 = hs_viol;
      repeat (4) begin
         @(posedge clk); #1;
         checks++; if (bus.bus_handshake_ack !== 1'b0) begin errors++; $display("FAIL hs_idle_ack: got %b want 0", bus.bus_handshake_ack); end
      end
      bus_phase(2'b00, 8'h11, 5, al, dl, ol, rd, hc, oa, da);
      checks++; if (hc !== 5) begin errors++; $display("FAIL hs_hold: got %0d want 5", hc); end
      checks++; if (dl !== 1 + c_SYNC_LAT) begin errors++; $display("FAIL hs_drop_lat: got %0d want %0d", dl, 1 + c_SYNC_LAT); end
      checks++; if (hs_viol - v0 !== 0) begin errors++; $display("FAIL hs_rules: got %0d want 0", hs_viol - v0); end
   endtask

   task automatic test_seq_err();
      int al, dl, ol, hc;
      logic [7:0] rd, da;
      logic oa;
      acc_t e, o;
      do_reset();
      mem_wait = 0;
      rd_val   = 8'h3C;
      exp_q.push_back('{1'b0, 16'h0000, 8'h00});
      bus_phase(2'b10, 8'h00, 0, al, dl, ol, rd, hc, oa, da);
      checks++; if (al !== 3 + c_SYNC_LAT) begin errors++; $display("FAIL seq_rd_ack_lat: got %0d want %0d", al, 3 + c_SYNC_LAT); end
      checks++; if (rd !== 8'h3C) begin errors++; $display("FAIL seq_rd_data: got %h want 3c", rd); end
      checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_set: got %b want 1", seq_err); end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL seq_access: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL seq_access: got %h want %h", o, e); end end
      exp_q.push_back('{1'b1, 16'h0102, 8'h77});
      bus_phase(2'b00, 8'h02, 0, al, dl, ol, rd, hc, oa, da);
      bus_phase(2'b01, 8'h01, 0, al, dl, ol, rd, hc, oa, da);
      bus_phase(2'b11, 8'h77, 0, al, dl, ol, rd, hc, oa, da);
      checks++; if (seq_err !== 1'b1) begin errors++; $display("FAIL seq_err_sticky: got %b want 1", seq_err); end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL seq_access2: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL seq_access2: got %h want %h", o, e); end end
   endtask

   task automatic test_reset_midop();
      int al, dl, ol, hc, n;
      logic [7:0] rd, da;
      logic oa;
      acc_t e, o;
      mem_wait = 20;
      @(negedge clk);
      bus.bus_handshake_req = 1'b1;
      bus.bus_state         = 2'b10;
      bus.bus_data_in       = 8'h00;
      n = 0;
      while (!mem_req && n < 20) begin @(posedge clk); #1; n++; end
      checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL midop_mem_req: got %b want 1", mem_req); end
      @(negedge clk); #1;
      rst_n = 1'b0;
      #1;
      checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL midop_rst_mem_req: got %b want 0", mem_req); end
      checks++; if (bus.bus_handshake_ack !== 1'b0) begin errors++; $display("FAIL midop_rst_ack: got %b want 0", bus.bus_handshake_ack); end
      checks++; if (bus.bus_output_enable !== 1'b0) begin errors++; $display("FAIL midop_rst_oe: got %b want 0", bus.bus_output_enable); end
      bus.bus_handshake_req = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      checks++; if (obs_q.size() !== 0) begin errors++; $display("FAIL midop_no_access: got %0d want 0", obs_q.size()); end
      mem_wait = 1;
      exp_q.push_back('{1'b1, 16'h5566, 8'h99});
      bus_phase(2'b00, 8'h66, 0, al, dl, ol, rd, hc, oa, da);
      bus_phase(2'b01, 8'h55, 0, al, dl, ol, rd, hc, oa, da);
      bus_phase(2'b11, 8'h99, 0, al, dl, ol, rd, hc, oa, da);
      checks++; if (al !== 2 + mem_wait + c_SYNC_LAT) begin errors++; $display("FAIL midop_wr_ack_lat: got %0d want %0d", al, 2 + mem_wait + c_SYNC_LAT); end
      checks++; if (seq_err !== 1'b0) begin errors++; $display("FAIL midop_seq_err: got %b want 0", seq_err); end
      e = exp_q.pop_front();
      checks++;
      if (obs_q.size() == 0) begin errors++; $display("FAIL midop_access: got none want %h", e); end
      else begin o = obs_q.pop_front(); if (o !== e) begin errors++; $display("FAIL midop_access: got %h want %h", o, e); end end
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_handshake();
      test_seq_err();
      test_reset_midop();
      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
